// File: rtl/prime_accum_pkg.sv
`default_nettype none
// ============================================================================
// prime_accum_pkg : state encoding and width helper for the prime accumulator
// Rev 1.0
// ============================================================================
package prime_accum_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DIV   = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int sq_width(input int w);
        return 2 * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prime_mod_unit.sv
`default_nettype none
// ============================================================================
// prime_mod_unit : restoring sequential remainder, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module prime_mod_unit
    import prime_accum_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem,
    output logic         rem_valid
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_ge;

    // Partial remainder is always below the divisor, so W+1 bits hold the shift.
    always_comb begin
        w_shift = {r_rem, r_dvd[W-1]};
        w_diff  = w_shift - {1'b0, r_dvs};
        w_ge    = (w_shift >= {1'b0, r_dvs});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (go) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_cnt   <= CW'(W);
            r_valid <= 1'b0;
        end else if (r_cnt != '0) begin
            r_dvd   <= {r_dvd[W-2:0], 1'b0};
            r_rem   <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
            r_cnt   <= r_cnt - CW'(1);
            r_valid <= (r_cnt == CW'(1));
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign rem       = r_rem;
    assign rem_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/prime_accum_seq.sv
`default_nettype none
// ============================================================================
// prime_accum_seq : finds the first n primes from a by trial division,
//                   streaming each prime with a running sum and count
// Rev 1.0
// ============================================================================
module prime_accum_seq
    import prime_accum_pkg::*;
#(
    parameter int W     = 32,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     n,
    output logic             busy,
    output logic             done,
    output logic             prime_valid,
    output logic [W-1:0]     prime_out,
    output logic [SUM_W-1:0] sum_out,
    output logic [W-1:0]     count,
    output logic             sum_ovf,
    output logic             range_err
);
    localparam int DDW = sq_width(W);

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_cand, w_cand_nxt;
    logic [W-1:0]     r_target, w_target_nxt;
    logic [W-1:0]     r_d, w_d_nxt;
    logic [W-1:0]     r_count, w_count_nxt;
    logic [W-1:0]     r_prime_out, w_prime_out_nxt;
    logic [SUM_W-1:0] r_sum, w_sum_nxt;
    logic             r_is_prime, w_is_prime_nxt;
    logic             r_prime_valid, w_prime_valid_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_rerr, w_rerr_nxt;

    logic             w_go;
    logic [W-1:0]     w_divisor;
    logic [W-1:0]     w_rem;
    logic             w_rem_valid;
    logic [W-1:0]     w_d_inc;
    logic [W-1:0]     w_count_inc;
    logic [W-1:0]     w_count_after;
    logic [DDW-1:0]   w_dd;
    logic [SUM_W:0]   w_sum_ext;

    prime_mod_unit #(.W(W)) u_mod (
        .clk       (clk),
        .reset     (reset),
        .go        (w_go),
        .dividend  (r_cand),
        .divisor   (w_divisor),
        .rem       (w_rem),
        .rem_valid (w_rem_valid)
    );

    assign w_d_inc       = r_d + W'(1);
    assign w_count_inc   = r_count + W'(1);
    assign w_count_after = r_is_prime ? w_count_inc : r_count;
    assign w_dd          = DDW'(w_d_inc) * DDW'(w_d_inc);
    assign w_sum_ext     = {1'b0, r_sum} + (SUM_W+1)'(r_cand);

    always_comb begin
        w_state_nxt       = r_state;
        w_cand_nxt        = r_cand;
        w_target_nxt      = r_target;
        w_d_nxt           = r_d;
        w_count_nxt       = r_count;
        w_prime_out_nxt   = r_prime_out;
        w_sum_nxt         = r_sum;
        w_is_prime_nxt    = r_is_prime;
        w_prime_valid_nxt = 1'b0;
        w_ovf_nxt         = r_ovf;
        w_rerr_nxt        = r_rerr;
        w_go              = 1'b0;
        w_divisor         = r_d;

        case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (start) begin
                    w_cand_nxt   = a;
                    w_target_nxt = n;
                    w_sum_nxt    = '0;
                    w_count_nxt  = '0;
                    w_ovf_nxt    = 1'b0;
                    w_rerr_nxt   = 1'b0;
                    w_state_nxt  = CHECK;
                end
            end
            CHECK: begin
                if (r_count == r_target) begin
                    w_state_nxt = DONE;
                end else if (r_cand < W'(2)) begin
                    w_is_prime_nxt = 1'b0;
                    w_state_nxt    = NEXT;
                end else if (r_cand == W'(2) || r_cand == W'(3)) begin
                    w_is_prime_nxt = 1'b1;
                    w_state_nxt    = NEXT;
                end else begin
                    w_d_nxt     = W'(2);
                    w_divisor   = W'(2);
                    w_go        = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                // Divisors are tried in order, so once (d+1)^2 exceeds cand no factor remains.
                if (w_rem_valid) begin
                    if (w_rem == '0) begin
                        w_is_prime_nxt = 1'b0;
                        w_state_nxt    = NEXT;
                    end else if (w_dd > DDW'(r_cand)) begin
                        w_is_prime_nxt = 1'b1;
                        w_state_nxt    = NEXT;
                    end else begin
                        w_d_nxt   = w_d_inc;
                        w_divisor = w_d_inc;
                        w_go      = 1'b1;
                    end
                end
            end
            NEXT: begin
                if (r_is_prime) begin
                    w_prime_valid_nxt = 1'b1;
                    w_prime_out_nxt   = r_cand;
                    w_count_nxt       = w_count_inc;
                    w_sum_nxt         = w_sum_ext[SUM_W-1:0];
                    if (w_sum_ext[SUM_W]) begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                if (r_cand == '1 && w_count_after < r_target) begin
                    w_rerr_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cand_nxt  = r_cand + W'(1);
                    w_state_nxt = CHECK;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cand        <= '0;
            r_target      <= '0;
            r_d           <= '0;
            r_count       <= '0;
            r_prime_out   <= '0;
            r_sum         <= '0;
            r_is_prime    <= 1'b0;
            r_prime_valid <= 1'b0;
            r_ovf         <= 1'b0;
            r_rerr        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cand        <= w_cand_nxt;
            r_target      <= w_target_nxt;
            r_d           <= w_d_nxt;
            r_count       <= w_count_nxt;
            r_prime_out   <= w_prime_out_nxt;
            r_sum         <= w_sum_nxt;
            r_is_prime    <= w_is_prime_nxt;
            r_prime_valid <= w_prime_valid_nxt;
            r_ovf         <= w_ovf_nxt;
            r_rerr        <= w_rerr_nxt;
        end
    end

    assign busy        = (r_state == CHECK) || (r_state == DIV) || (r_state == NEXT);
    assign done        = (r_state == DONE);
    assign prime_valid = r_prime_valid;
    assign prime_out   = r_prime_out;
    assign sum_out     = r_sum;
    assign count       = r_count;
    assign sum_ovf     = r_ovf;
    assign range_err   = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_prime_accum_seq.sv
`default_nettype none
// ============================================================================
// tb_prime_accum_seq : bench for prime_accum_seq at W=32/SUM_W=40 and W=8/SUM_W=8
// Rev 1.0
// ============================================================================
module tb_prime_accum_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        t_start = 1'b0;
    logic [31:0] t_a = '0;
    logic [31:0] t_n = '0;
    logic        sel8 = 1'b0;

    always #5 clk = ~clk;

    logic        start32, start8;
    logic        busy32, done32, pv32, ovf32, rerr32;
    logic [31:0] po32, count32;
    logic [39:0] sum32;
    logic        busy8, done8, pv8, ovf8, rerr8;
    logic [7:0]  po8, count8, sum8;

    assign start32 = t_start & ~sel8;
    assign start8  = t_start & sel8;

    prime_accum_seq #(.W(32), .SUM_W(40)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .a(t_a), .n(t_n),
        .busy(busy32), .done(done32), .prime_valid(pv32), .prime_out(po32),
        .sum_out(sum32), .count(count32), .sum_ovf(ovf32), .range_err(rerr32)
    );

    prime_accum_seq #(.W(8), .SUM_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(t_a[7:0]), .n(t_n[7:0]),
        .busy(busy8), .done(done8), .prime_valid(pv8), .prime_out(po8),
        .sum_out(sum8), .count(count8), .sum_ovf(ovf8), .range_err(rerr8)
    );

    logic        m_busy, m_done, m_pv, m_ovf, m_rerr;
    logic [31:0] m_po, m_count;
    logic [39:0] m_sum;

    always_comb begin
        if (sel8) begin
            m_busy = busy8; m_done = done8; m_pv = pv8; m_ovf = ovf8; m_rerr = rerr8;
            m_po = {24'd0, po8}; m_count = {24'd0, count8}; m_sum = {32'd0, sum8};
        end else begin
            m_busy = busy32; m_done = done32; m_pv = pv32; m_ovf = ovf32; m_rerr = rerr32;
            m_po = po32; m_count = count32; m_sum = sum32;
        end
    end

    logic [31:0] obs_p[$];
    logic [31:0] obs_c[$];
    logic [39:0] obs_s[$];
    logic        obs_o[$];
    int          ndone = 0;

    always @(negedge clk) begin
        if (m_pv) begin
            obs_p.push_back(m_po);
            obs_c.push_back(m_count);
            obs_s.push_back(m_sum);
            obs_o.push_back(m_ovf);
        end
        if (m_done) ndone++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: plain trial division over every candidate, true (unbounded) sum.
    longint exp_p[$];
    longint exp_s[$];
    bit     exp_o[$];
    bit     exp_rerr;

    function automatic bit ref_is_prime(input longint x);
        if (x < 2) return 1'b0;
        for (longint d = 2; d * d <= x; d++) begin
            if (x % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic ref_run(input bit s8, input longint a, input longint n);
        longint maxv  = s8 ? 64'd255 : 64'hFFFF_FFFF;
        longint mask  = s8 ? 64'd255 : ((64'd1 << 40) - 1);
        longint c     = a;
        longint total = 0;
        exp_p.delete(); exp_s.delete(); exp_o.delete();
        exp_rerr = 1'b0;
        while (exp_p.size() < n) begin
            if (ref_is_prime(c)) begin
                total += c;
                exp_p.push_back(c);
                exp_s.push_back(total & mask);
                exp_o.push_back(total > mask);
            end
            if (exp_p.size() < n && c == maxv) begin
                exp_rerr = 1'b1;
                break;
            end
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel8 = s[0];
            #1;
            n_checks++;
            if ({m_busy, m_done, m_pv, m_ovf, m_rerr} !== 5'b0 || m_po !== 0 || m_sum !== 0 || m_count !== 0) begin
                n_fail++;
                $display("FAIL reset_state sel8=%0d: busy=%b done=%b pv=%b ovf=%b rerr=%b po=%0d sum=%0d count=%0d, all required 0",
                         s, m_busy, m_done, m_pv, m_ovf, m_rerr, m_po, m_sum, m_count);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run(input string name, input bit s8, input longint a, input longint n, input bit mid_start);
        int base, d0, got;
        bit seen;
        longint fsum;
        ref_run(s8, a, n);
        sel8 = s8;
        @(negedge clk);
        base = obs_p.size();
        d0   = ndone;
        t_a = 32'(a); t_n = 32'(n); t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        n_checks++;
        if (m_busy !== 1'b1 || m_count !== 0 || m_sum !== 0 || m_ovf !== 1'b0 || m_rerr !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_clear: busy=%b count=%0d sum=%0d ovf=%b rerr=%b, required busy=1 and rest 0",
                     name, m_busy, m_count, m_sum, m_ovf, m_rerr);
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
            if (mid_start && cyc == 6) begin
                t_a = t_a + 40; t_n = 1; t_start = 1'b1;
            end else begin
                t_start = 1'b0;
            end
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        t_start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: done=0 after 30000 cycles, required done=1", name);
        end
        fsum = (exp_s.size() > 0) ? exp_s[exp_s.size()-1] : 0;
        n_checks++;
        if (m_count !== 32'(exp_p.size()) || m_sum !== 40'(fsum) || m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s final: count=%0d sum=%0d busy=%b, required count=%0d sum=%0d busy=0",
                     name, m_count, m_sum, m_busy, exp_p.size(), fsum);
        end
        n_checks++;
        if (m_ovf !== ((exp_o.size() > 0) ? exp_o[exp_o.size()-1] : 1'b0) || m_rerr !== exp_rerr) begin
            n_fail++;
            $display("FAIL %s flags: ovf=%b rerr=%b, required ovf=%b rerr=%b", name, m_ovf, m_rerr,
                     (exp_o.size() > 0) ? exp_o[exp_o.size()-1] : 1'b0, exp_rerr);
        end
        got = obs_p.size() - base;
        n_checks++;
        if (got != exp_p.size()) begin
            n_fail++;
            $display("FAIL %s prime_count: got %0d pulses, required %0d", name, got, exp_p.size());
        end
        for (int k = 0; k < exp_p.size() && k < got; k++) begin
            n_checks++;
            if (obs_p[base+k] !== 32'(exp_p[k]) || obs_c[base+k] !== 32'(k + 1) ||
                obs_s[base+k] !== 40'(exp_s[k]) || obs_o[base+k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL %s pulse[%0d]: prime=%0d count=%0d sum=%0d ovf=%b, required %0d %0d %0d %b",
                         name, k, obs_p[base+k], obs_c[base+k], obs_s[base+k], obs_o[base+k],
                         exp_p[k], k + 1, exp_s[k], exp_o[k]);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ndone - d0 != 1 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: %0d pulses, done now %b, required 1 pulse then 0", name, ndone - d0, m_done);
        end
    endtask

    task automatic test_n_zero();
        int base, d0;
        sel8 = 1'b0;
        @(negedge clk);
        base = obs_p.size(); d0 = ndone;
        t_a = 7; t_n = 0; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        n_checks++;
        if (m_busy !== 1'b1 || m_done !== 1'b0) begin
            n_fail++;
            $display("FAIL n_zero cycle1: busy=%b done=%b, required busy=1 done=0", m_busy, m_done);
        end
        @(negedge clk);
        n_checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_count !== 0 || m_sum !== 0) begin
            n_fail++;
            $display("FAIL n_zero cycle2: done=%b busy=%b count=%0d sum=%0d, required done=1 busy=0 count=0 sum=0",
                     m_done, m_busy, m_count, m_sum);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs_p.size() != base || ndone - d0 != 1) begin
            n_fail++;
            $display("FAIL n_zero pulses: %0d primes and %0d done pulses, required 0 and 1", obs_p.size() - base, ndone - d0);
        end
    endtask

    task automatic test_back_to_back();
        int base, d0;
        bit seen;
        logic [31:0] exp_bb[4];
        exp_bb = '{32'd23, 32'd29, 32'd31, 32'd37};
        sel8 = 1'b1;
        @(negedge clk);
        base = obs_p.size(); d0 = ndone;
        t_a = 20; t_n = 2; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !seen; cyc++) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        t_a = 30; t_n = 2; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        n_checks++;
        if (!seen || m_busy !== 1'b1 || m_count !== 0) begin
            n_fail++;
            $display("FAIL b2b restart: first_done=%b busy=%b count=%0d, required 1 1 0", seen, m_busy, m_count);
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !seen; cyc++) begin
            @(negedge clk);
            if (m_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen || m_sum !== 40'd68 || m_count !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b second_run: done=%b sum=%0d count=%0d, required 1 68 2", seen, m_sum, m_count);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs_p.size() - base != 4 || ndone - d0 != 2) begin
            n_fail++;
            $display("FAIL b2b totals: %0d primes %0d done pulses, required 4 and 2", obs_p.size() - base, ndone - d0);
        end
        for (int k = 0; k < 4 && base + k < obs_p.size(); k++) begin
            n_checks++;
            if (obs_p[base+k] !== exp_bb[k]) begin
                n_fail++;
                $display("FAIL b2b prime[%0d]: got %0d, required %0d", k, obs_p[base+k], exp_bb[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        bit seen;
        logic [31:0] exp_r[3];
        exp_r = '{32'd1009, 32'd1013, 32'd1019};
        sel8 = 1'b0;
        @(negedge clk);
        base = obs_p.size();
        t_a = 1000; t_n = 10; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(negedge clk);
            #1;
            if (obs_p.size() >= base + 3) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid timeout: %0d primes seen, required 3", obs_p.size() - base);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({m_busy, m_done, m_pv, m_ovf, m_rerr} !== 5'b0 || m_po !== 0 || m_sum !== 0 || m_count !== 0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: busy=%b done=%b pv=%b ovf=%b rerr=%b po=%0d sum=%0d count=%0d, all required 0",
                     m_busy, m_done, m_pv, m_ovf, m_rerr, m_po, m_sum, m_count);
        end
        for (int k = 0; k < 3 && base + k < obs_p.size(); k++) begin
            n_checks++;
            if (obs_p[base+k] !== exp_r[k]) begin
                n_fail++;
                $display("FAIL reset_mid prime[%0d]: got %0d, required %0d", k, obs_p[base+k], exp_r[k]);
            end
        end
        reset = 1'b0;
        test_run("after_reset", 1'b0, 2, 3, 1'b0);
    endtask

    task automatic test_random();
        bit     s8;
        longint a, n;
        for (int i = 0; i < 6; i++) begin
            s8 = 1'($urandom_range(0, 1));
            if (s8) begin
                a = $urandom_range(0, 255);
                n = $urandom_range(0, 6);
            end else begin
                a = $urandom_range(0, 400);
                n = $urandom_range(1, 5);
            end
            test_run($sformatf("rand%0d_w%0d_a%0d_n%0d", i, s8 ? 8 : 32, a, n), s8, a, n, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_run("a10_n4_ignored_start", 1'b0, 10, 4, 1'b1);
        test_run("a0_n5", 1'b0, 0, 5, 1'b0);
        test_n_zero();
        test_run("w8_sum_overflow", 1'b1, 100, 3, 1'b0);
        test_run("w8_range_err", 1'b1, 250, 3, 1'b0);
        test_run("w8_range_cleared", 1'b1, 2, 1, 1'b0);
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prime_accum_seq.md
Name: prime_accum_seq

Overview:
- Multi-cycle, synthesizable prime finder and accumulator.
- On a start pulse it searches upward from a start value `a` for the first `n` primes, using trial division by a sequential remainder unit.
- Each prime found is streamed out with a valid pulse, and a running sum and count are kept.
- Used as a parametrised arithmetic practice/datapath block. It replaces single-cycle loop-based prime logic with a bounded-latency FSM and start/busy/done handshake.

Parameters:
- W, 32, width of start value, count and candidate/prime datapath (even, ≥4).
- SUM_W, 40, width of the sum accumulator.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; latch `a`, `n` and begin a run. Ignored while busy=1.
- a  in  W  first candidate to test.
- n  in  W  number of primes to find.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- prime_valid  out  1  one-cycle pulse per prime found.
- prime_out  out  W  prime value; valid when prime_valid=1, holds last prime otherwise.
- sum_out  out  SUM_W  running sum of primes found (mod 2^SUM_W).
- count  out  W  primes found so far in this run.
- sum_ovf  out  1  sticky; sum exceeded 2^SUM_W-1 this run.
- range_err  out  1  sticky; candidate would pass 2^W-1 before n primes were found.

Behaviour:
- Reset: all outputs 0 (busy, done, prime_valid, prime_out, sum_out, count, sum_ovf, range_err). FSM goes to IDLE; any in-flight division is abandoned. Reset mid-run is legal and takes priority over all other activity.
- Start in IDLE/DONE: latch cand=a and target=n; clear sum_out, count, sum_ovf, range_err; go to CHECK. busy rises the next cycle.
- FSM states: IDLE, CHECK, DIV, NEXT, DONE.
- IDLE/DONE: wait for start. DONE is entered for one cycle, in which done=1 and busy=0, then returns to IDLE.
- CHECK, in priority order:
  - If count==target, go to DONE. This covers n=0: done pulses 2 cycles after start, sum_out=0.
  - If cand<2, mark composite and go to NEXT.
  - If cand==2 or 3, mark prime and go to NEXT.
  - Otherwise set d=2, pulse the mod unit with (cand, d), go to DIV.
- DIV: wait for rem_valid. Then:
  - rem==0 → composite → NEXT.
  - Else d←d+1. If d*d > cand (computed at 2W width, no overflow), the candidate is prime → NEXT. Otherwise re-launch the mod unit with the new d and stay in DIV.
- NEXT, if prime:
  - prime_valid=1 and prime_out=cand.
  - count and sum_out update in the same registered cycle, so values seen with prime_valid already include this prime.
  - sum_ovf is set if the carry out of SUM_W is 1.
- NEXT, candidate advance (prime or not):
  - If cand==2^W-1 and count (after update) < target: set range_err → DONE.
  - Else cand←cand+1 → CHECK.
- Arithmetic: sum is zero-extended prime added mod 2^SUM_W. count never exceeds target.
- Latency per trial division: W+1 cycles (mod unit W cycles plus launch). Worst case per candidate is about (2^(W/2)-1)*(W+1) + 3 cycles.
- start while busy: ignored. start in the same cycle as DONE: accepted, and the new run begins.

Decomposition:
- Package prime_accum_pkg:
  - typedef for the state enum: IDLE, CHECK, DIV, NEXT, DONE.
  - localparam function for the d*d compare width (2W).
- Sub-module prime_mod_unit #(W):
  - Restoring sequential remainder.
  - Inputs: clk, reset, go, dividend[W], divisor[W].
  - Outputs: rem[W], rem_valid (one-cycle pulse, exactly W cycles after go).
  - go while computing restarts the operation.

Test Plan:
- a=10, n=4 → prime_valid pulses with 11, 13, 17, 19; count=1..4; final sum_out=60; one done pulse; sum_ovf=0, range_err=0.
- a=0, n=5 → primes 2, 3, 5, 7, 11 in order (0 and 1 rejected); sum_out=28; count=5.
- n=0, a=7 → no prime_valid; done 2 cycles after start; sum_out=0, count=0. A start pulse during a busy run (a=10, n=4) is ignored and the results match scenario 1.
- W=8, SUM_W=8, a=100, n=3 → primes 101, 103, 107; sum_out=55 (311 mod 256); sum_ovf=1 from the third prime onward.
- W=8, a=250, n=3 → 251 emitted; 252–255 rejected; range_err=1, count=1, done pulses; a new start clears range_err.
- Reset asserted mid-run (a=1000, n=10, after the 3rd prime) → next cycle all outputs 0 and IDLE. A fresh start (a=2, n=3) then yields 2, 3, 5 with sum_out=10.
